// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences imem requests, steers the PC register,
// parks a fetched word while decode stalls, and drains a stale request after a redirect.
module fetch_ctrl #(
  parameter int unsigned     BW        = 32,
  parameter logic [BW-1:0]   RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] pc_cur,
  output logic [BW-1:0] pc_next,
  output logic          pc_stall,
  input  logic          stall_id,
  input  logic          redirect_valid,
  input  logic [BW-1:0] redirect_target,
  output logic          imem_req,
  output logic [BW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [BW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [BW-1:0] instr_out,
  output logic          if_flush
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;

  localparam logic [BW-1:0] INC = BW'(4);

  state_t        state, state_d;
  logic [BW-1:0] addr_q, addr_d;
  logic [BW-1:0] instr_q, instr_d;
  logic [BW-1:0] pc_inc;

  // Wraps modulo 2^BW by construction.
  assign pc_inc    = pc_cur + INC;
  assign imem_addr = addr_q;
  assign instr_out = (state == REQ) ? imem_rdata : instr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      addr_q  <= RESET_VEC;
      instr_q <= '0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    instr_d  = instr_q;
    pc_next  = pc_cur;
    pc_stall = 1'b1;
    imem_req = 1'b0;
    if_valid = 1'b0;
    if_flush = 1'b0;
    unique case (state)
      BOOT: begin
        pc_next  = RESET_VEC;
        pc_stall = 1'b0;
        addr_d   = RESET_VEC;
        state_d  = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_next  = redirect_target;
          pc_stall = 1'b0;
          if_flush = 1'b1;
          // Without an ack the old request is still in flight and must be drained.
          if (imem_ack) addr_d  = redirect_target;
          else          state_d = DRAIN;
        end else if (imem_ack) begin
          if (!stall_id) begin
            if_valid = 1'b1;
            pc_next  = pc_inc;
            pc_stall = 1'b0;
            addr_d   = pc_inc;
          end else begin
            instr_d = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if (redirect_valid) begin
          if_valid = 1'b0;
          if_flush = 1'b1;
          pc_next  = redirect_target;
          pc_stall = 1'b0;
          addr_d   = redirect_target;
          state_d  = REQ;
        end else if (!stall_id) begin
          pc_next  = pc_inc;
          pc_stall = 1'b0;
          addr_d   = pc_inc;
          state_d  = REQ;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_next  = redirect_target;
          pc_stall = 1'b0;
          if_flush = 1'b1;
        end
        // Returned data is stale; pc_cur already points at the redirect target.
        if (imem_ack) begin
          addr_d  = redirect_valid ? redirect_target : pc_cur;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a second instance with a wrapping reset vector
// shares the stimulus; each instance drives its own PC register model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic [31:0] pc_cur = '0, pc_next, imem_addr, instr_out;
  logic        pc_stall, imem_req, if_valid, if_flush;
  logic [31:0] pc_cur2 = '0, pc_next2, imem_addr2, instr_out2;
  logic        pc_stall2, imem_req2, if_valid2, if_flush2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.BW(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_stall(pc_stall),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .instr_out(instr_out), .if_flush(if_flush)
  );

  fetch_ctrl #(.BW(32), .RESET_VEC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_cur(pc_cur2), .pc_next(pc_next2), .pc_stall(pc_stall2),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid2), .instr_out(instr_out2), .if_flush(if_flush2)
  );

  // PC registers of the surrounding pipeline.
  always @(posedge clk) begin
    if (!pc_stall)  pc_cur  <= pc_next;
    if (!pc_stall2) pc_cur2 <= pc_next2;
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0;
    repeat (2) next_cyc();
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else pass_cnt++;
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid); else pass_cnt++;
    chk_cnt++; if (if_flush !== 1'b0) $display("FAIL rst_flush got %b exp 0", if_flush); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", imem_addr); else pass_cnt++;
    chk_cnt++; if (instr_out !== 32'h0) $display("FAIL rst_instr got %h exp 00000000", instr_out); else pass_cnt++;
    chk_cnt++; if (imem_addr2 !== 32'hFFFF_FFFC) $display("FAIL rst_addr2 got %h exp fffffffc", imem_addr2); else pass_cnt++;
    next_cyc();
    rst = 1'b1;
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL boot_req got %b exp 0", imem_req); else pass_cnt++;
    next_cyc();
    #1;
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL first_req got %b exp 1", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h exp 00000000", imem_addr); else pass_cnt++;
    chk_cnt++; if (pc_stall !== 1'b1) $display("FAIL wait_stall got %b exp 1", pc_stall); else pass_cnt++;
    next_cyc();
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL wait_addr got %h exp 00000000", imem_addr); else pass_cnt++;
  endtask

  task automatic test_seq();
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; stall_id = 1'b0; imem_rdata = 32'hA000_0000 + i;
      #1;
      chk_cnt++; if (imem_addr !== 32'(4*i)) $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 32'(4*i)); else pass_cnt++;
      chk_cnt++; if (if_valid !== 1'b1) $display("FAIL seq_valid%0d got %b exp 1", i, if_valid); else pass_cnt++;
      chk_cnt++; if (instr_out !== 32'hA000_0000 + i) $display("FAIL seq_instr%0d got %h exp %h", i, instr_out, 32'hA000_0000 + i); else pass_cnt++;
      chk_cnt++; if (pc_next !== 32'(4*i+4) || pc_stall !== 1'b0) $display("FAIL seq_pc%0d got %h/%b exp %h/0", i, pc_next, pc_stall, 32'(4*i+4)); else pass_cnt++;
      next_cyc();
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; stall_id = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_cnt++; if (imem_addr !== 32'h10) $display("FAIL stall_addr got %h exp 00000010", imem_addr); else pass_cnt++;
    chk_cnt++; if (if_valid !== 1'b0 || pc_stall !== 1'b1) $display("FAIL stall_ack got %b/%b exp 0/1", if_valid, pc_stall); else pass_cnt++;
    next_cyc();
    imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if (instr_out !== 32'hDEAD_BEEF) $display("FAIL hold_instr%0d got %h exp deadbeef", i, instr_out); else pass_cnt++;
      chk_cnt++; if (if_valid !== 1'b1 || imem_req !== 1'b0 || pc_stall !== 1'b1) $display("FAIL hold_ctl%0d got v%b r%b s%b exp v1 r0 s1", i, if_valid, imem_req, pc_stall); else pass_cnt++;
      if (i < 2) next_cyc();
    end
    stall_id = 1'b0;
    #1;
    chk_cnt++; if (pc_next !== 32'h14 || pc_stall !== 1'b0) $display("FAIL hold_rel got %h/%b exp 00000014/0", pc_next, pc_stall); else pass_cnt++;
    next_cyc();
    chk_cnt++; if (imem_addr !== 32'h14 || imem_req !== 1'b1) $display("FAIL rel_req got %h/%b exp 00000014/1", imem_addr, imem_req); else pass_cnt++;
    // Advance to 0x20.
    imem_ack = 1'b1;
    repeat (3) next_cyc();
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_drain();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    #1;
    chk_cnt++; if (imem_addr !== 32'h20) $display("FAIL rd_addr got %h exp 00000020", imem_addr); else pass_cnt++;
    chk_cnt++; if (if_flush !== 1'b1 || if_valid !== 1'b0) $display("FAIL rd_flush got f%b v%b exp f1 v0", if_flush, if_valid); else pass_cnt++;
    chk_cnt++; if (pc_next !== 32'h100 || pc_stall !== 1'b0) $display("FAIL rd_pc got %h/%b exp 00000100/0", pc_next, pc_stall); else pass_cnt++;
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) $display("FAIL drain_req got %b/%h exp 1/00000020", imem_req, imem_addr); else pass_cnt++;
    chk_cnt++; if (if_flush !== 1'b0 || if_valid !== 1'b0 || pc_stall !== 1'b1) $display("FAIL drain_ctl got f%b v%b s%b exp f0 v0 s1", if_flush, if_valid, pc_stall); else pass_cnt++;
    next_cyc();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk_cnt++; if (if_valid !== 1'b0 || imem_addr !== 32'h20) $display("FAIL drain_ack got v%b %h exp v0 00000020", if_valid, imem_addr); else pass_cnt++;
    next_cyc();
    imem_ack = 1'b0;
    #1;
    chk_cnt++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) $display("FAIL drain_next got %h/%b exp 00000100/1", imem_addr, imem_req); else pass_cnt++;
  endtask

  task automatic test_hold_redirect();
    imem_ack = 1'b1; stall_id = 1'b1; imem_rdata = 32'h0000_0013;
    next_cyc();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
    #1;
    chk_cnt++; if (if_valid !== 1'b0 || if_flush !== 1'b1) $display("FAIL hr_flush got v%b f%b exp v0 f1", if_valid, if_flush); else pass_cnt++;
    chk_cnt++; if (pc_next !== 32'h200 || pc_stall !== 1'b0 || imem_req !== 1'b0) $display("FAIL hr_pc got %h/%b/%b exp 00000200/0/0", pc_next, pc_stall, imem_req); else pass_cnt++;
    next_cyc();
    redirect_valid = 1'b0; stall_id = 1'b0;
    #1;
    chk_cnt++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) $display("FAIL hr_next got %h/%b exp 00000200/1", imem_addr, imem_req); else pass_cnt++;
    // Redirect coinciding with an ack in REQ retargets directly.
    imem_ack = 1'b1; stall_id = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
    #1;
    chk_cnt++; if (if_valid !== 1'b0 || if_flush !== 1'b1 || pc_next !== 32'h300) $display("FAIL ra_out got v%b f%b %h exp v0 f1 00000300", if_valid, if_flush, pc_next); else pass_cnt++;
    next_cyc();
    imem_ack = 1'b0; redirect_valid = 1'b0; stall_id = 1'b0;
    #1;
    chk_cnt++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) $display("FAIL ra_next got %h/%b exp 00000300/1", imem_addr, imem_req); else pass_cnt++;
  endtask

  task automatic test_drain_reset();
    redirect_valid = 1'b1; redirect_target = 32'h400;
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) $display("FAIL dr_pre got %b/%h exp 1/00000300", imem_req, imem_addr); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_flush !== 1'b0) $display("FAIL dr_async got r%b v%b f%b exp 0 0 0", imem_req, if_valid, if_flush); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL dr_addr got %h exp 00000000", imem_addr); else pass_cnt++;
    repeat (2) next_cyc();
    rst = 1'b1;
    next_cyc();
    #1;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL dr_restart got %b/%h exp 1/00000000", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    chk_cnt++; if (imem_addr2 !== 32'hFFFF_FFFC || imem_req2 !== 1'b1) $display("FAIL wrap_first got %h/%b exp fffffffc/1", imem_addr2, imem_req2); else pass_cnt++;
    imem_ack = 1'b1; stall_id = 1'b0; imem_rdata = 32'h0000_0093;
    #1;
    chk_cnt++; if (pc_next2 !== 32'h0 || if_valid2 !== 1'b1) $display("FAIL wrap_pc got %h/%b exp 00000000/1", pc_next2, if_valid2); else pass_cnt++;
    next_cyc();
    imem_ack = 1'b0;
    #1;
    chk_cnt++; if (imem_addr2 !== 32'h0) $display("FAIL wrap_addr got %h exp 00000000", imem_addr2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect_drain();
    test_hold_redirect();
    test_drain_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BW, default 32, SHALL set the address and instruction width.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc_cur  input  BW  SHALL carry the current PC register value.
REQ-006 pc_next  output  BW  SHALL carry the next-PC value to the PC register.
REQ-007 pc_stall  output  1  SHALL be 1 when the PC register holds its value.
REQ-008 stall_id  input  1  SHALL be the decode-stage hazard stall; 1 means hold.
REQ-009 redirect_valid  input  1  SHALL flag a branch or jump redirect from execute.
REQ-010 redirect_target  input  BW  SHALL be the redirect address, valid with redirect_valid.
REQ-011 imem_req  output  1  SHALL be the instruction-memory request.
REQ-012 imem_addr  output  BW  SHALL be the request address.
REQ-013 imem_ack  input  1  SHALL flag a completed request, with imem_rdata valid in the same cycle.
REQ-014 imem_rdata  input  BW  SHALL carry the returned instruction word.
REQ-015 if_valid  output  1  SHALL flag instr_out as a valid instruction for IF/ID.
REQ-016 instr_out  output  BW  SHALL carry the fetched instruction.
REQ-017 if_flush  output  1  SHALL pulse 1 for one cycle to flush IF/ID on redirect.

Function
REQ-018 The FSM SHALL have the states BOOT, REQ, HOLD and DRAIN; register addr_q (BW) SHALL hold the outstanding address; register instr_q (BW) SHALL hold the fetched word.
REQ-019 imem_addr SHALL equal addr_q; instr_out SHALL equal imem_rdata in REQ and instr_q otherwise.
REQ-020 pc_next, pc_stall, imem_req, if_valid and if_flush SHALL be combinational from the state and current inputs; all defaults SHALL be pc_stall=1, pc_next=pc_cur, and the other outputs 0.
REQ-021 BOOT SHALL drive pc_next=RESET_VEC and pc_stall=0, load addr_q=RESET_VEC, and go to REQ on the next cycle.
REQ-022 REQ SHALL drive imem_req=1, with addr_q held constant until imem_ack.
REQ-023 REQ, on imem_ack with no redirect and stall_id=0, SHALL drive if_valid=1, pc_next=pc_cur+4 and pc_stall=0, load addr_q=pc_cur+4, and stay in REQ.
REQ-024 REQ, on imem_ack with no redirect and stall_id=1, SHALL load instr_q=imem_rdata and go to HOLD, with if_valid=0 that cycle.
REQ-025 REQ, with no imem_ack and no redirect, SHALL hold the PC and stay in REQ.
REQ-026 REQ, on redirect_valid, SHALL drive pc_next=redirect_target, pc_stall=0 and if_flush=1, with if_valid=0; with imem_ack it SHALL load addr_q=redirect_target and stay in REQ; without imem_ack it SHALL go to DRAIN with addr_q unchanged.
REQ-027 HOLD SHALL drive if_valid=1 and imem_req=0.
REQ-028 HOLD, on stall_id=0, SHALL drive pc_next=pc_cur+4 and pc_stall=0, load addr_q=pc_cur+4, and go to REQ.
REQ-029 HOLD, on redirect_valid, SHALL take priority over stall_id: if_valid=0, if_flush=1, pc_next=redirect_target, pc_stall=0, addr_q=redirect_target, and go to REQ.
REQ-030 DRAIN SHALL drive imem_req=1 on the old addr_q and if_valid=0.
REQ-031 DRAIN, on imem_ack, SHALL discard the data, load addr_q=pc_cur and go to REQ.
REQ-032 DRAIN, on redirect_valid, SHALL drive pc_next=redirect_target, pc_stall=0 and if_flush=1.
REQ-033 DRAIN, on simultaneous imem_ack and redirect_valid, SHALL load addr_q=redirect_target.
REQ-034 PC+4 SHALL be computed modulo 2^BW, so 0xFFFF_FFFC+4 wraps to 0x0000_0000.
REQ-035 redirect_valid SHALL override stall_id in every state; stall_id SHALL never suppress a redirect.

Reset
REQ-036 Asserting rst SHALL force state=BOOT, addr_q=RESET_VEC and instr_q=0 immediately, with imem_req=0, if_valid=0 and if_flush=0, regardless of any outstanding request.
REQ-037 After reset release, the first rising edge SHALL leave BOOT, and imem_req SHALL assert in the following cycle with imem_addr=RESET_VEC.

Verification
REQ-038 Reset, then ack every cycle with stall_id=0 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; if_valid=1 in each ack cycle.
REQ-039 At address 0x10, ack with stall_id=1 for 3 cycles -> HOLD, instr_out stable, pc_stall=1, imem_req=0; on release pc_next=0x14.
REQ-040 Request at 0x20 with ack delayed 2 cycles, redirect to 0x100 in the first wait cycle -> if_flush pulse, DRAIN keeps imem_addr=0x20, ack discarded (if_valid=0), next request addr 0x100.
REQ-041 redirect_valid together with stall_id=1 in HOLD -> redirect wins, if_valid=0, next request at the target.
REQ-042 RESET_VEC=0xFFFF_FFFC, one ack -> next imem_addr=0x0000_0000.
REQ-043 Assert rst during DRAIN -> immediately BOOT, imem_req=0; restart fetch at RESET_VEC.
